// File: rtl/uart_tx_result_if.sv
// Handshake and serial-line bundle for uart_tx_result.
// The bench drives it through master and the transmitter uses slave.
interface uart_tx_result_if #(
    parameter int NB_DATA = 8
);
    logic               i_tx_start;
    logic [NB_DATA-1:0] i_data;
    logic               o_tx;
    logic               o_tx_busy;
    logic               o_tx_done;

    modport master (
        output i_tx_start, i_data,
        input  o_tx, o_tx_busy, o_tx_done
    );

    modport slave (
        input  i_tx_start, i_data,
        output o_tx, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx_result.sv
// UART transmitter for the ALU result byte: 8N1 by default, and 8E1 when
// UART_TX_PARITY_EN is defined. Bit timing uses 16 oversample ticks per bit.
module uart_tx_result #(
    parameter int NB_DATA = 8,
    parameter int CLK_DIV = 163,
    parameter int SB_TICK = 16
) (
    input  logic            i_clock,
    input  logic            i_reset,
    uart_tx_result_if.slave bus
);
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int TW       = $clog2(TICK_MAX);
    localparam int BW       = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [NB_DATA-1:0] shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic tick;
    logic bit_end;

    assign tick    = (div_q == DW'(CLK_DIV - 1));
    assign bit_end = tick && (tick_cnt_q == TW'(15));

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != S_IDLE) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) tick_cnt_d = tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // Accept clears the divider so each frame starts phase-aligned.
                if (bus.i_tx_start) begin
                    state_d    = S_START;
                    div_d      = '0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shreg_d    = bus.i_data;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^bus.i_data;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    shreg_d    = shreg_q >> 1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BW'(NB_DATA - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick && (tick_cnt_q == TW'(SB_TICK - 1))) begin
                    tick_cnt_d = '0;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the next state so o_tx comes straight from a flop.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_tx_busy = (state_q != S_IDLE);
    assign bus.o_tx_done = done_q;

endmodule
